// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: memory-op encodings and reset defaults.
package mem_wb_stage_pkg;

  // Memory operation carried down the pipeline with each instruction.
  // Codes 9..15 are unused and behave like MOP_NONE.
  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LW   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LHU  = 4'd3,
    MOP_LB   = 4'd4,
    MOP_LBU  = 4'd5,
    MOP_SW   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SB   = 4'd8
  } mem_op_e;

  // pc_W value after reset or a flush bubble.
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  // Default data memory depth in 32-bit words.
  localparam int DM_WORDS_DEFAULT = 3072;

endpackage

// File: rtl/mem_wb_stage_dm_byte_ram.sv
// Word-organised data memory with per-byte write enables and an async clear.
module dm_byte_ram #(
  parameter int DM_WORDS = 3072,
  parameter int AW       = $clog2(DM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DM_WORDS];

  // Clear every word on reset; otherwise write only the enabled byte lanes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Asynchronous read; indices beyond the array read as zero rather than aliasing.
  always_comb begin
    rdata = '0;
    if (int'(addr) < DM_WORDS) begin
      rdata = mem[addr];
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data memory access with lane select/extension, plus the MEM/WB register.
module mem_wb_stage #(
  parameter int          DM_WORDS = mem_wb_stage_pkg::DM_WORDS_DEFAULT,
  parameter logic [31:0] PC_RESET = mem_wb_stage_pkg::PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] M_nInstr,
  input  logic [31:0] M_pc,
  input  logic [31:0] M_pcPlus8,
  input  logic [31:0] M_aluRes,
  input  logic [31:0] M_wrData,
  input  logic [3:0]  M_memOp,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] nInstr_W,
  output logic [31:0] pc_W,
  output logic [31:0] pcPlus8_W,
  output logic [31:0] aluRes_W,
  output logic [31:0] memData_W
);

  import mem_wb_stage_pkg::*;

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

  logic        addr_valid;
  logic [1:0]  lane;
  logic        is_load;
  logic        is_store;
  logic [3:0]  be;
  logic [31:0] store_data;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign addr_valid = (M_aluRes < DM_BYTES);
  assign lane       = M_aluRes[1:0];

  dm_byte_ram #(
    .DM_WORDS (DM_WORDS),
    .AW       (AW)
  ) u_dm (
    .clk   (clk),
    .reset (reset),
    .we    (dm_we),
    .be    (be),
    .addr  (M_aluRes[AW+1:2]),
    .wdata (store_data),
    .rdata (rd_word)
  );

  // Decode the memory op into load/store flags, byte enables and lane-replicated store data.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    be         = 4'b0000;
    store_data = M_wrData;
    case (M_memOp)
      MOP_LW, MOP_LH, MOP_LHU, MOP_LB, MOP_LBU: is_load = 1'b1;
      MOP_SW: begin
        is_store = 1'b1;
        be       = 4'b1111;
      end
      MOP_SH: begin
        is_store   = 1'b1;
        be         = M_aluRes[1] ? 4'b1100 : 4'b0011;
        store_data = {M_wrData[15:0], M_wrData[15:0]};
      end
      MOP_SB: begin
        is_store   = 1'b1;
        be         = 4'b0001 << lane;
        store_data = {4{M_wrData[7:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half from the read word and extend it; out-of-range loads give zero.
  always_comb begin
    byte_sel  = rd_word[{lane, 3'b000} +: 8];
    half_sel  = M_aluRes[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    if (is_load && addr_valid) begin
      case (M_memOp)
        MOP_LW:  load_data = rd_word;
        MOP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
        MOP_LHU: load_data = {16'h0000, half_sel};
        MOP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
        MOP_LBU: load_data = {24'h000000, byte_sel};
        default: load_data = '0;
      endcase
    end
  end

  // Build the full word that the store will leave in memory, for the trace port.
  always_comb begin
    merged = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = store_data[8*b +: 8];
      end
    end
  end

  assign dm_we    = reset && enable && !flush && addr_valid && is_store;
  assign dm_addr  = {M_aluRes[31:2], 2'b00};
  assign dm_wdata = merged;

  // MEM/WB register: hold when stalled, take bubble values on flush, otherwise capture M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nInstr_W  <= '0;
      pc_W      <= PC_RESET;
      pcPlus8_W <= PC_RESET + 32'd8;
      aluRes_W  <= '0;
      memData_W <= '0;
    end else if (enable) begin
      if (flush) begin
        nInstr_W  <= '0;
        pc_W      <= PC_RESET;
        pcPlus8_W <= PC_RESET + 32'd8;
        aluRes_W  <= '0;
        memData_W <= '0;
      end else begin
        nInstr_W  <= M_nInstr;
        pc_W      <= M_pc;
        pcPlus8_W <= M_pcPlus8;
        aluRes_W  <= M_aluRes;
        memData_W <= load_data;
      end
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Contains the byte-addressable data memory: stores of word/half/byte, loads with sign or zero extension.
- Also contains the MEM/WB pipeline register that feeds write-back.
- Exposes a combinational store-trace port for the testbench logger.

Parameters:
DM_WORDS, 3072, data memory depth in 32-bit words (byte range 0 .. 4*DM_WORDS-1)
PC_RESET, 32'h00003000, pc_W value after reset or flush

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = MEM/WB register advances and stores commit; 0 = hold, no store
flush  input  1  synchronous bubble insert into W (honoured only when enable=1)
M_nInstr  input  32  instruction in MEM
M_pc  input  32  pc of instruction in MEM
M_pcPlus8  input  32  link value
M_aluRes  input  32  ALU result / effective byte address
M_wrData  input  32  forwarded rt store data
M_memOp  input  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 = none
dm_we  output  1  store committing this cycle (combinational)
dm_addr  output  32  word-aligned byte address of that store
dm_wdata  output  32  full merged word written
nInstr_W  output  32  registered instruction
pc_W  output  32  registered pc
pcPlus8_W  output  32  registered link value
aluRes_W  output  32  registered ALU result
memData_W  output  32  registered extended load data; 0 for non-loads

Behaviour:
- Reset (reset=0, asynchronous):
  - nInstr_W, aluRes_W, memData_W = 0; pc_W = PC_RESET; pcPlus8_W = PC_RESET+8.
  - All DM words cleared.
  - While reset=0, no store commits and dm_we=0.
- Priority on each rising clk edge: reset > enable=0 (hold all, no store) > flush (W regs take reset values, no store) > normal.
- Address decode:
  - word index = M_aluRes[31:2]; byte lane = M_aluRes[1:0].
  - Valid iff M_aluRes < 4*DM_WORDS.
- Read path:
  - Asynchronous read of DM[word index].
  - lw: full word, lane bits ignored.
  - lh/lhu: half selected by M_aluRes[1] (1 = bits 31:16), then sign/zero extended.
  - lb/lbu: byte selected by lane (lane 3 = bits 31:24), then sign/zero extended.
  - Result registered into memData_W → one-cycle latency; visible in W the cycle after the load is in M.
- Write path:
  - Byte enables: sw=1111; sh=0011 or 1100 by M_aluRes[1]; sb=one-hot of lane.
  - Store data replicated to lanes (sh: {wd[15:0],wd[15:0]}; sb: 4x wd[7:0]).
  - Merged word = old word with enabled lanes replaced.
  - Commits at the rising edge while enable=1, flush=0, reset=1 and address valid.
  - dm_we/dm_addr/dm_wdata describe exactly that commit, during the cycle before the edge.
- Out of range:
  - Invalid-address store: dropped, dm_we=0.
  - Invalid-address load: memData_W=0.
- Misalignment: no exception; low address bits are ignored as above.
- Ordering: a load in the cycle after a store to the same word observes the new data (memory already updated at the edge).
- Non-memory ops: memData_W=0; other fields pass through unchanged.
- Reset deasserted mid-pipeline: the next edge behaves normally with the current inputs.

Decomposition:
- Shared package holds:
  - memOp encodings (MOP_NONE..MOP_SB);
  - PC_RESET;
  - default DM_WORDS.
- One sub-module: dm_byte_ram.
  - Contents: DM_WORDS x 32 array, async read, 4-bit byte-enable synchronous write, async active-low clear.
  - The stage instantiates it and holds the lane/extension logic plus the W register.

Test Plan:
- Reset then idle: assert reset=0 mid-cycle → outputs immediately 0 / pc_W=0x3000 / pcPlus8_W=0x3008; memData_W=0 after a lw of address 0x10.
- sw 0x12345678 @0x20, then lb @0x23, lbu @0x20, lh @0x22, lhu @0x20 → memData_W = 0x00000012, 0x00000078, 0x00001234, 0x00005678, one cycle after each load.
- sw 0x80FF7F01 @0x40, then lb @0x42, lh @0x42 → 0xFFFFFFFF, 0xFFFF80FF; sb 0xAB @0x41 → dm_wdata=0x80FFAB01, dm_addr=0x40, dm_we=1.
- sh 0xBEEF @0x0A over word 0 → DM[2]=0xBEEF0000; a following lw @0x08 returns 0xBEEF0000 back-to-back.
- enable=0 during sw @0x10 → no commit, dm_we=0, W regs hold; flush=1 with sw → no commit, W regs = reset values.
- sw @0x3000 (=4*DM_WORDS) → dm_we=0, memory unchanged; lw @0x2FFC after sw 0xCAFEBABE there → 0xCAFEBABE.
